// File: rtl/mult_accum.sv
// Batch accumulator for a 12x12 multiplier stream, with a one-deep output slot and HOLD stall.
// Build option MULT_ACCUM_SAT_EN: saturate the accumulator on carry out instead of wrapping.

module mult_accum #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [23:0]              in_result,
    input  logic                     in_done,
    input  logic                     clear,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(LEN+1)-1:0] count,
    output logic                     ovf,
    output logic                     drop
);
    localparam int unsigned CNT_W = $clog2(LEN+1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_d;
    logic [ACC_W-1:0] out_sum_d;
    logic             out_valid_d, ovf_d, drop_d;

    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_val;
    logic             carry, transfer, slot_free, last;

    assign sum_ext   = {1'b0, acc_q} + (ACC_W+1)'(in_result);
    assign carry     = sum_ext[ACC_W];
    assign transfer  = out_valid & out_ready;
    assign slot_free = ~out_valid | transfer;
    assign last      = (count == CNT_W'(LEN - 1));

`ifdef MULT_ACCUM_SAT_EN
    // Once clamped, further non-zero products carry again and keep it clamped.
    assign sum_val = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    assign sum_val = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ACCUM;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (in_done && last && !slot_free) state_d = HOLD;
                HOLD:  if (transfer) state_d = ACCUM;
            endcase
        end
    end

    // Next values for the accumulator and the registered outputs.
    always_comb begin
        acc_d       = acc_q;
        count_d     = count;
        out_sum_d   = out_sum;
        out_valid_d = out_valid;
        ovf_d       = ovf;
        drop_d      = drop;
        if (transfer) out_valid_d = 1'b0;
        if (clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_done) begin
                        if (carry) ovf_d = 1'b1;
                        if (last && slot_free) begin
                            out_sum_d   = sum_val;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            count_d     = '0;
                        end else if (last) begin
                            acc_d   = sum_val;
                            count_d = CNT_W'(LEN);
                        end else begin
                            acc_d   = sum_val;
                            count_d = count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        out_sum_d   = acc_q;
                        out_valid_d = 1'b1;
                        acc_d       = in_done ? ACC_W'(in_result) : '0;
                        count_d     = in_done ? CNT_W'(1) : '0;
                    end else if (in_done) begin
                        drop_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            count     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count     <= count_d;
            out_sum   <= out_sum_d;
            out_valid <= out_valid_d;
            ovf       <= ovf_d;
            drop      <= drop_d;
        end
    end

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter LEN, default 4, is the number of products per batch, with LEN >= 2.
REQ-002 Parameter ACC_W, default 32, is the accumulator and output width, with ACC_W >= 24.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_result, input, 24 bits: the product from the upstream 12x12 multiplier.
REQ-006 Port in_done, input, 1 bit: product valid; one pulse per product; there is no backpressure to the multiplier.
REQ-007 Port clear, input, 1 bit: synchronous abort of the current batch.
REQ-008 Port out_sum, output, ACC_W bits: the completed batch sum.
REQ-009 Port out_valid, output, 1 bit: out_sum holds an unconsumed batch.
REQ-010 Port out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-011 Port count, output, $clog2(LEN+1) bits: the number of products accumulated in the current batch.
REQ-012 Port ovf, output, 1 bit: sticky flag, set when any batch exceeds ACC_W bits.
REQ-013 Port drop, output, 1 bit: sticky flag, set when a product is discarded.

Function
REQ-014 The block SHALL have states ACCUM (collecting products) and HOLD (batch complete, output slot occupied).
REQ-015 In ACCUM, on in_done, the block SHALL set acc <= acc + zero-extended in_result and count <= count + 1.
REQ-016 In ACCUM, when in_done arrives with count == LEN-1 and the slot is free, it SHALL load out_sum with acc + in_result, set out_valid, zero acc and count, and remain in ACCUM.
- The slot is free when out_valid is low, or when a transfer occurs in that same cycle.
REQ-017 Batch latency SHALL be 1 cycle: out_valid is high in the cycle after the final in_done.
REQ-018 In ACCUM, when in_done arrives with count == LEN-1 and the slot is not free, acc SHALL take the final sum, count SHALL read LEN, and the state SHALL go to HOLD.
REQ-019 In HOLD, in_done SHALL discard the product and set drop; acc and count are unchanged.
REQ-020 In HOLD, on a transfer, the block SHALL set out_sum <= acc, keep out_valid high, zero acc and count, and go to ACCUM.
- An in_done in that same cycle SHALL start the new batch: acc <= in_result, count <= 1, no drop.
REQ-021 In ACCUM, a transfer with no new batch completing SHALL clear out_valid.
REQ-022 out_sum SHALL be stable while out_valid is high and out_ready is low.
REQ-023 On clear, the block SHALL zero acc and count, go to ACCUM, and clear ovf and drop; clear takes priority over in_done in the same cycle.
REQ-024 clear SHALL NOT alter out_sum or out_valid; a pending HOLD batch is discarded.
REQ-025 Addition SHALL be unsigned and ACC_W bits wide; ovf is set on any carry out of bit ACC_W-1.

Reset
REQ-026 reset_n low SHALL immediately force state ACCUM and zero acc, count, out_sum, out_valid, ovf and drop.
REQ-027 Reset mid-batch or in HOLD SHALL lose all in-flight data; the first in_done after release starts a fresh batch.
REQ-028 Reset release SHALL be synchronised externally; the block only requires that reset_n deassert away from a clk edge.

Configuration
REQ-029 With macro MULT_ACCUM_SAT_EN defined, on a carry out the accumulator SHALL clamp to all-ones, hold there for the rest of the batch, and set ovf.
REQ-030 Without MULT_ACCUM_SAT_EN, the sum SHALL wrap modulo 2^ACC_W, and ovf is still set.

Verification
REQ-031 Basic batch: LEN=4, out_ready=1; products 3, 5, 7, 9 on consecutive cycles -> out_valid high for 1 cycle, one cycle after the 4th product, with out_sum=24; ovf=0, drop=0.
REQ-032 Stall and hold: out_ready=0; two batches of 4 x 0xFFFFFF -> first out_sum=0x3FFFFFC, state HOLD, count=4; a 9th product sets drop=1; raising out_ready -> second out_sum=0x3FFFFFC presented next cycle.
REQ-033 Same-cycle release: in HOLD, product 10 arrives in the same cycle as the transfer -> new batch count=1; no drop.
REQ-034 Clear: after 2 products, clear asserted together with in_done -> count=0 and acc=0; the product is ignored; out_valid unchanged.
REQ-035 Overflow: ACC_W=24; products 0xFFFFFF then 2 -> wrap build gives 0x000001 with ovf=1; MULT_ACCUM_SAT_EN build gives 0xFFFFFF with ovf=1.
REQ-036 Async reset: reset_n pulsed low between clk edges in HOLD -> all outputs 0 before the next edge; a subsequent batch of 1, 1, 1, 1 gives out_sum=4.
